// File: rtl/data_mem_responder_if.sv
// Load/store bus between the MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_width;
  logic [31:0] mem_rd_data;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_width,
    input  mem_rd_data, mem_ready, mem_err
  );

  modport slave (
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_width,
    output mem_rd_data, mem_ready, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised array serving byte/half/word loads and
// stores with a registered ready/error pulse after WAIT_CYCLES wait states.
// Load data is right-aligned and zero-extended; sign extension happens downstream.
module data_mem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        err_q;
  logic [31:0] rd_data_q;
  logic        req_rd_q;
  logic        req_wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  width_q;

  logic [31:0] mem_q [2**ADDR_WIDTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  eff_rd;
  logic                  eff_wr;
  logic [31:0]           eff_addr;
  logic [31:0]           eff_wdata;
  logic [3:0]            eff_width;
  logic [1:0]            offset;
  logic [6:0]            lane_mask;
  logic                  width_ok;
  logic [31:0]           offset_addr;
  logic                  reject;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           rd_word;
  logic [31:0]           byte_mask;
  logic [31:0]           store_data;
  logic                  store_en;
  logic                  err_d;
  logic [31:0]           rd_data_d;

  // Decode the access that completes on the next edge: live bus inputs when it is
  // accepted straight into RESP, the latched request when it leaves WAIT.
  always_comb begin
    accept      = (state_q != WAIT) && (bus.mem_rd_en || bus.mem_wr_en);
    enter_resp  = (accept && (WAIT_CYCLES == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));
    eff_rd      = (state_q == WAIT) ? req_rd_q : bus.mem_rd_en;
    eff_wr      = (state_q == WAIT) ? req_wr_q : bus.mem_wr_en;
    eff_addr    = (state_q == WAIT) ? addr_q   : bus.mem_addr;
    eff_wdata   = (state_q == WAIT) ? wdata_q  : bus.mem_wr_data;
    eff_width   = (state_q == WAIT) ? width_q  : bus.mem_width;
    offset      = eff_addr[1:0];
    lane_mask   = {3'b000, eff_width} << offset;
    width_ok    = (eff_width == 4'b0001) || (eff_width == 4'b0011) || (eff_width == 4'b1111);
    offset_addr = eff_addr - BASE_ADDR;
    reject      = (lane_mask[6:4] != 3'b000) || !width_ok || (eff_addr < BASE_ADDR) ||
                  ((offset_addr >> (ADDR_WIDTH + 2)) != 32'd0) || (eff_rd && eff_wr);
    word_idx    = offset_addr[ADDR_WIDTH+1:2];
    rd_word     = mem_q[word_idx];
    byte_mask   = {{8{eff_width[3]}}, {8{eff_width[2]}}, {8{eff_width[1]}}, {8{eff_width[0]}}};
    store_data  = eff_wdata << {offset, 3'b000};
    store_en    = enter_resp && eff_wr && !reject && !reset;
    err_d       = reject;
    rd_data_d   = (eff_rd && !reject) ? ((rd_word >> {offset, 3'b000}) & byte_mask) : 32'd0;
  end

  // Request FSM with registered ready/error/read-data response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= 32'd0;
      req_rd_q  <= 1'b0;
      req_wr_q  <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      width_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            req_rd_q <= bus.mem_rd_en;
            req_wr_q <= bus.mem_wr_en;
            addr_q   <= bus.mem_addr;
            wdata_q  <= bus.mem_wr_data;
            width_q  <= bus.mem_width;
            if (WAIT_CYCLES == 0) begin
              state_q   <= RESP;
              ready_q   <= 1'b1;
              err_q     <= err_d;
              rd_data_q <= rd_data_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
              ready_q <= 1'b0;
              err_q   <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q   <= RESP;
            ready_q   <= 1'b1;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane store into the array on the edge that enters RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) begin
          mem_q[word_idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_ready   = ready_q;
  assign bus.mem_err     = err_q;
  assign bus.mem_rd_data = rd_data_q;

endmodule
